// File: rtl/mips_store_logger_pkg.sv
// mips_log_pkg: shared types and constants for the MIPS store logger.
//   log_entry_t   one logged store (addr, data, and pc when STORE_LOG_PC_EN
//                 is defined; 96-bit entries in that build, 64-bit otherwise)
//   done_state_t  completion FSM states (RUN, DONE)
//   DONE_ADDR_DEF / DONE_DATA_DEF  default completion-store address/data
//   DROP_W        width of the saturating drop counter
// Optional feature macro: STORE_LOG_PC_EN
package mips_log_pkg;

    localparam int          DROP_W        = 16;
    localparam logic [31:0] DONE_ADDR_DEF = 32'd84;
    localparam logic [31:0] DONE_DATA_DEF = 32'd7;

    typedef struct packed {
`ifdef STORE_LOG_PC_EN
        logic [31:0] pc;
`endif
        logic [31:0] addr;
        logic [31:0] data;
    } log_entry_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } done_state_t;

endpackage

// File: rtl/mips_store_logger_if.sv
// mips_store_logger_if: store-port tap plus drain handshake of the logger.
//   memwrite/dataadr/writedata/pc : sampled data-memory write port
//   out_valid/out_ready           : drain handshake (head entry)
//   out_addr/out_data/out_pc      : head entry fields
//   count/overflow/drop_count/misaligned/done : status
// Modports: master = store source and drain consumer (bench side),
//           slave  = the logger itself.
interface mips_store_logger_if #(
    parameter int DEPTH = 8
);
    import mips_log_pkg::*;

    logic                       memwrite;
    logic [31:0]                dataadr;
    logic [31:0]                writedata;
    logic [31:0]                pc;
    logic                       out_valid;
    logic                       out_ready;
    logic [31:0]                out_addr;
    logic [31:0]                out_data;
    logic [31:0]                out_pc;
    logic [$clog2(DEPTH):0]     count;
    logic                       overflow;
    logic [DROP_W-1:0]          drop_count;
    logic                       misaligned;
    logic                       done;

    modport master (
        output memwrite, dataadr, writedata, pc, out_ready,
        input  out_valid, out_addr, out_data, out_pc, count,
               overflow, drop_count, misaligned, done
    );

    modport slave (
        input  memwrite, dataadr, writedata, pc, out_ready,
        output out_valid, out_addr, out_data, out_pc, count,
               overflow, drop_count, misaligned, done
    );

endinterface

// File: rtl/mips_store_logger_fifo.sv
// mips_log_fifo: synchronous FIFO of log_entry_t with a registered head.
//   clk, reset : clock, synchronous active-high reset
//   push, din  : write request and entry (accepted when not full, or when
//                full with a same-cycle pop)
//   pop        : remove head (ignored when empty)
//   dout       : head register; holds the last head when empty
//   full, empty, count : occupancy status
module mips_log_fifo
    import mips_log_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  log_entry_t             din,
    input  logic                   pop,
    output log_entry_t             dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    log_entry_t        mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    log_entry_t        head_q, head_d;
    logic              do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop)
            count_d = count_q + CNT_W'(1);
        else if (!do_push && do_pop)
            count_d = count_q - CNT_W'(1);
        // The head register tracks the entry at the next read pointer. If
        // that slot is being written this very edge (empty FIFO), forward
        // the incoming entry since the array does not hold it yet.
        head_d = head_q;
        if (count_d != '0)
            head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? din : mem[rd_ptr_d];
    end

    // Storage array carries no reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign dout  = head_q;
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/mips_store_logger.sv
// mips_store_logger: observes the MIPS data-memory write port, logs every
// store into a DEPTH-entry FIFO and drains it over a valid/ready handshake.
//   clk, reset : clock, synchronous active-high reset
//   bus        : mips_store_logger_if.slave (store tap, drain port, status)
// Status: sticky overflow, saturating drop_count, sticky misaligned,
// done from the RUN/DONE completion FSM.
// Optional feature macro: STORE_LOG_PC_EN (log and present the store PC;
// otherwise pc is ignored and out_pc is tied to 0).
module mips_store_logger
    import mips_log_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] DONE_ADDR = DONE_ADDR_DEF,
    parameter logic [31:0] DONE_DATA = DONE_DATA_DEF
) (
    input  logic                clk,
    input  logic                reset,
    mips_store_logger_if.slave  bus
);
    log_entry_t         entry_in;
    log_entry_t         head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               drop;
    logic               hit_done;
    logic [DROP_W-1:0]  drop_count_q, drop_count_d;
    logic               overflow_q, overflow_d;
    logic               misaligned_q, misaligned_d;
    done_state_t        state_q;

    always_comb begin
        entry_in      = '0;
        entry_in.addr = bus.dataadr;
        entry_in.data = bus.writedata;
`ifdef STORE_LOG_PC_EN
        entry_in.pc   = bus.pc;
`endif
    end

    assign pop      = !fifo_empty && bus.out_ready;
    // A full FIFO still accepts a store when the head leaves the same edge.
    assign drop     = bus.memwrite && fifo_full && !pop;
    assign hit_done = bus.memwrite && (bus.dataadr == DONE_ADDR) &&
                      (bus.writedata == DONE_DATA);

    mips_log_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.memwrite),
        .din   (entry_in),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (bus.count)
    );

    always_comb begin
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != {DROP_W{1'b1}}))
            drop_count_d = drop_count_q + DROP_W'(1);
        overflow_d   = overflow_q || drop;
        misaligned_d = misaligned_q || (bus.memwrite && (bus.dataadr[1:0] != 2'b00));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Completion FSM: the matching store counts even if it is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:  if (hit_done) state_q <= ST_DONE;
                ST_DONE: state_q <= ST_DONE;
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign bus.out_valid  = !fifo_empty;
    assign bus.out_addr   = head.addr;
    assign bus.out_data   = head.data;
`ifdef STORE_LOG_PC_EN
    assign bus.out_pc     = head.pc;
`else
    assign bus.out_pc     = 32'd0;
`endif
    assign bus.overflow   = overflow_q;
    assign bus.drop_count = drop_count_q;
    assign bus.misaligned = misaligned_q;
    assign bus.done       = (state_q == ST_DONE);

endmodule

// File: doc/mips_store_logger.md
# mips_store_logger

Downstream observer of the MIPS data-memory write port. Captures every store (`memwrite` high) into a bounded FIFO and drains it to a testbench or checker over a valid/ready handshake. Also flags the program-completion store and misaligned stores, and counts stores dropped on overflow. Sits beside the data memory, sampling the same `memwrite`/`dataadr`/`writedata`/`pc` signals the processor drives.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `DONE_ADDR`, 32'd84: completion-store address.
- `DONE_DATA`, 32'd7: completion-store data.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `memwrite`  in  1  store strobe, one store per high cycle.
- `dataadr`  in  32  store byte address.
- `writedata`  in  32  store data.
- `pc`  in  32  PC of the storing instruction. Port always present.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer accepts head.
- `out_addr`  out  32  head address.
- `out_data`  out  32  head data.
- `out_pc`  out  32  head PC. Driven 0 when `STORE_LOG_PC_EN` is undefined.
- `count`  out  $clog2(DEPTH)+1  occupancy.
- `overflow`  out  1  sticky: at least one store dropped.
- `drop_count`  out  16  dropped stores, saturating at 16'hFFFF.
- `misaligned`  out  1  sticky: a store had `dataadr[1:0]` != 0.
- `done`  out  1  sticky completion flag.

## Operation
- Push: `memwrite` high in a cycle.
- Pop: `out_valid && out_ready`.
- Push when not full: entry written at the tail.
- Push when full with a same-cycle pop: accepted. Occupancy stays at DEPTH.
- Push when full without a pop: dropped. `drop_count` increments (saturating) and `overflow` sets.
- Pop when empty: impossible, since `out_valid` is low.
- Ordering: strict FIFO. Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH.
- `misaligned`: set when a push has `dataadr[1:0]` != 0, whether or not the entry is stored. The entry is still logged.
- Completion FSM, states RUN and DONE:
  - RUN to DONE on any push with `dataadr == DONE_ADDR && writedata == DONE_DATA`, even if that push is dropped.
  - DONE holds until reset.
  - `done` = (state == DONE).
- `out_*` are driven from the head register. Their values are undefined-but-stable when `out_valid` is low (implemented as the last head).

## Timing
- Reset values (sync): `out_valid`=0, `out_addr`/`out_data`/`out_pc`=0, `count`=0, `overflow`=0, `drop_count`=0, `misaligned`=0, `done`=0, FSM=RUN, pointers=0.
- Reset mid-operation discards all entries on the next edge. A push in the reset cycle is ignored.
- Latency: a push at edge N makes the entry visible, with `out_valid` high, after edge N when the FIFO was empty. No combinational bypass from `memwrite` to `out_valid`.
- `count`, `overflow`, `drop_count`, `misaligned` and `done` update at the same edge as the causing push or pop.
- `out_valid` stays high and `out_*` stay stable until the pop edge.
- `out_ready` may toggle freely; no dependency on `out_valid`.

## Configuration
- `STORE_LOG_PC_EN` defined: each entry stores `pc` (96-bit entries), and `out_pc` presents the head PC.
- `STORE_LOG_PC_EN` undefined: entries are 64-bit, the `pc` input is ignored, and `out_pc` is tied to 0.
- Port list is identical in both builds.

## Structure
- Package `mips_log_pkg`:
  - `log_entry_t` packed struct (`addr`, `data`, and `pc` under the macro).
  - `DONE_ADDR_DEF` and `DONE_DATA_DEF` constants.
  - `DROP_W` = 16.
- Sub-module `mips_log_fifo`: generic synchronous FIFO of `log_entry_t`, parameter DEPTH, push/pop/full/empty/count.
- Top level holds the drop counter, sticky flags and completion FSM.

## Test plan
- Reset, then a store to 0x50 with data 0xDEADBEEF and pc 0x3C. Required: `out_valid` high the next cycle with `out_addr`=0x50, `out_data`=0xDEADBEEF, `out_pc`=0x3C (PC build), `count`=1.
- `out_ready`=0 and 10 consecutive stores at DEPTH=8. Required: `count`=8, `drop_count`=2, `overflow`=1, and the drained order matches the first 8 stores.
- FIFO full, store and pop in the same cycle. Required: `count` stays 8, no drop, and the new entry appears last.
- Store 7 to address 84 with the FIFO full and no pop. Required: `done`=1 next cycle, `drop_count` increments, and `done` stays high through further stores.
- Store to 0x53. Required: `misaligned`=1 and the entry is logged with `out_addr`=0x53.
- Reset asserted with 5 entries queued. Required: next cycle `count`=0, `out_valid`=0, and all flags clear.
